mean_arbiter: RTL and testbench
===============================

Name: mean_arbiter

Overview:
- Shares one mean datapath (A, B, sign in with input strobe; C out with output strobe) between NUM_REQ requesters.
- Round-robin grant; at most one issue per cycle.
- Tracks in-flight requester IDs in an order-preserving tag FIFO and routes each result back with its requester ID.
- Sits between client blocks and the single mean instance.

Parameters:
- NUM_REQ, 4, number of requester channels (2..8).
- DATA_W, 16, operand and result width.
- MAX_OUT, 4, maximum outstanding operations; tag FIFO depth, power of 2.
- TIMEOUT, 64, cycles allowed per operation (optional feature only).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  allow new grants.
- req_valid  in  NUM_REQ  per-requester request.
- req_ready  out  NUM_REQ  one-hot grant; combinational.
- req_a  in  NUM_REQ*DATA_W  packed operand A; channel i at [i*DATA_W +: DATA_W].
- req_b  in  NUM_REQ*DATA_W  packed operand B.
- req_sign  in  NUM_REQ  1 = signed operands.
- mean_a  out  DATA_W  operand A to datapath.
- mean_b  out  DATA_W  operand B to datapath.
- mean_sign  out  1  sign select to datapath.
- mean_input_strobe  out  1  issue pulse to datapath.
- mean_c  in  DATA_W  datapath result.
- mean_output_strobe  in  1  datapath result valid.
- rsp_valid  out  1  response pulse.
- rsp_id  out  $clog2(NUM_REQ)  requester that owns the response.
- rsp_data  out  DATA_W  result.
- busy  out  1  tag FIFO not empty.
- spurious_err  out  1  sticky: result strobe received while FIFO empty.

Behaviour:
- Reset values: all outputs 0; RR pointer 0; FIFO empty; error flags clear.
- Grant condition: enable && any req_valid && count < MAX_OUT (registered count).
- Grant selection: first valid channel at or after the pointer, wrapping.
- req_ready[g] = 1 in the grant cycle only; the handshake is req_valid & req_ready.
- On grant:
  - push g into the tag FIFO;
  - register req_a[g], req_b[g], req_sign[g];
  - pointer <= (g+1) mod NUM_REQ.
- Issue latency: mean_input_strobe = 1 exactly one cycle after the grant, with operands held stable; back-to-back grants give back-to-back strobes.
- mean_a, mean_b and mean_sign hold their last values when not strobing.
- Result path: mean_output_strobe pops the FIFO head. The next cycle drives rsp_valid = 1, rsp_id = head, rsp_data = mean_c (registered, 1-cycle latency).
- Responses return in issue order; the datapath is required to be in-order.
- Push and pop in the same cycle: both happen; count is unchanged.
- Full: no grant, even if a pop happens that cycle (the decision uses the registered count).
- Empty with mean_output_strobe = 1: no response; spurious_err set until reset.
- enable low: no new grants; in-flight results still return; the pointer holds.
- Reset mid-operation: FIFO flushed, pointer 0, pending issue cancelled. The datapath shares reset, so no stale results arrive.
- Widths: data passes through unmodified; no arithmetic in this block.

Optional Feature:
- Macro: MEAN_ARBITER_TIMEOUT_EN.
- When defined:
  - a counter runs while busy and reloads on every pop;
  - if it reaches TIMEOUT, the FIFO is flushed and the sticky output timeout_err (1 bit) is set until reset;
  - grants are blocked for the cycle of the flush.
- When undefined: no counter and no timeout_err port; operations wait indefinitely.

Decomposition:
- Package mean_arbiter_pkg: ID_W = $clog2(NUM_REQ), CNT_W = $clog2(MAX_OUT)+1, the tag typedef, and the default TIMEOUT constant.
- One sub-module: mean_arbiter_tag_fifo, a synchronous FIFO of ID_W-wide tags with push/pop/full/empty/count.
- Round-robin grant logic stays in the top level.

Test Plan:
- Single request, ch0, a=-31, b=11, sign=1 → req_ready[0] in the same cycle; mean_input_strobe one cycle later with the same operands; response rsp_id=0, rsp_data=-10.
- Single request, ch1, a=11, b=21, sign=0 → rsp_id=1, rsp_data=16, one cycle after mean_output_strobe.
- All four channels held valid, datapath model with 3-cycle latency → grants 0,1,2,3,0,1… on consecutive cycles; responses carry IDs in the same order.
- mean_output_strobe held low → exactly 4 grants, then req_ready stays 0 and busy=1. One strobe → one response, then one new grant the following cycle.
- mean_output_strobe pulsed after reset with no requests → no rsp_valid; spurious_err=1 until reset.
- With MEAN_ARBITER_TIMEOUT_EN and TIMEOUT=8, datapath stalled after one issue → timeout_err=1 on cycle 8, busy=0, grants resume.

Source files
------------

// File: rtl/mean_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mean_arbiter_pkg
// Purpose  : Shared constants, tag type and helper function for the mean
//            arbiter slice (default configuration values).
// Revision : 1.0 - initial release
// ============================================================================
package mean_arbiter_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int DATA_W_DEF  = 16;
    localparam int MAX_OUT_DEF = 4;
    localparam int TIMEOUT_DEF = 64;

    // Tag and occupancy widths for the default configuration
    localparam int ID_W  = $clog2(NUM_REQ_DEF);
    localparam int CNT_W = $clog2(MAX_OUT_DEF) + 1;

    typedef logic [ID_W-1:0] tag_t;

    // Round-robin successor of a channel index, wrapping at n
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mean_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mean_arbiter_if
// Purpose  : Bundles the requester side, the datapath side and the status
//            outputs of the mean arbiter.
//            slave  : arbiter view (requests/results in, grants/issue out)
//            master : environment view (clients + datapath)
//            timeout_err exists only with MEAN_ARBITER_TIMEOUT_EN defined.
// Revision : 1.0 - initial release
// ============================================================================
interface mean_arbiter_if
    import mean_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF
);
    localparam int c_id_w = $clog2(NUM_REQ);

    logic                       enable;
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*DATA_W-1:0]  req_a;
    logic [NUM_REQ*DATA_W-1:0]  req_b;
    logic [NUM_REQ-1:0]         req_sign;
    logic [DATA_W-1:0]          mean_a;
    logic [DATA_W-1:0]          mean_b;
    logic                       mean_sign;
    logic                       mean_input_strobe;
    logic [DATA_W-1:0]          mean_c;
    logic                       mean_output_strobe;
    logic                       rsp_valid;
    logic [c_id_w-1:0]          rsp_id;
    logic [DATA_W-1:0]          rsp_data;
    logic                       busy;
    logic                       spurious_err;
`ifdef MEAN_ARBITER_TIMEOUT_EN
    logic                       timeout_err;
`endif

    modport slave (
        input  enable, req_valid, req_a, req_b, req_sign, mean_c, mean_output_strobe,
        output req_ready, mean_a, mean_b, mean_sign, mean_input_strobe,
        output rsp_valid, rsp_id, rsp_data, busy, spurious_err
`ifdef MEAN_ARBITER_TIMEOUT_EN
        , output timeout_err
`endif
    );

    modport master (
        output enable, req_valid, req_a, req_b, req_sign, mean_c, mean_output_strobe,
        input  req_ready, mean_a, mean_b, mean_sign, mean_input_strobe,
        input  rsp_valid, rsp_id, rsp_data, busy, spurious_err
`ifdef MEAN_ARBITER_TIMEOUT_EN
        , input timeout_err
`endif
    );

endinterface
`default_nettype wire

// File: rtl/mean_arbiter_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mean_arbiter_tag_fifo
// Purpose  : Synchronous FIFO of requester tags, preserving issue order.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            i_flush       - drop all entries
//            i_push, i_tag - write a tag (ignored when full)
//            i_pop, o_tag  - read/advance head (ignored when empty)
//            o_full, o_empty, o_count - occupancy status
// Revision : 1.0 - initial release
// ============================================================================
module mean_arbiter_tag_fifo
    import mean_arbiter_pkg::*;
#(
    parameter int TAG_W     = ID_W,
    parameter int DEPTH     = MAX_OUT_DEF,
    parameter int CNT_WIDTH = CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_flush,
    input  logic                 i_push,
    input  logic [TAG_W-1:0]     i_tag,
    input  logic                 i_pop,
    output logic [TAG_W-1:0]     o_tag,
    output logic                 o_full,
    output logic                 o_empty,
    output logic [CNT_WIDTH-1:0] o_count
);
    localparam int c_ptr_w = $clog2(DEPTH);

    logic [TAG_W-1:0]     r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_wptr;
    logic [c_ptr_w-1:0]   r_rptr;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 w_do_push;
    logic                 w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_WIDTH'(DEPTH));
    assign o_count   = r_count;
    assign o_tag     = r_mem[r_rptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // Storage needs no reset: entries are only read while counted valid
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_tag;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mean_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mean_arbiter
// Purpose  : Round-robin sharing of one in-order mean datapath among NUM_REQ
//            requesters. Grants are issued one cycle later to the datapath;
//            requester IDs ride in a tag FIFO and tag each returned result.
// Ports    : clock, reset - clock, synchronous active-high reset
//            bus (slave)  - requests/grants, datapath issue/result,
//                           responses, busy and sticky error flags
// Options  : MEAN_ARBITER_TIMEOUT_EN - per-operation watchdog (TIMEOUT
//            cycles) that flushes the tag FIFO and sets sticky timeout_err.
// Revision : 1.0 - initial release
// ============================================================================
module mean_arbiter
    import mean_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MAX_OUT = MAX_OUT_DEF
`ifdef MEAN_ARBITER_TIMEOUT_EN
    , parameter int TIMEOUT = TIMEOUT_DEF
`endif
) (
    input  logic          clock,
    input  logic          reset,
    mean_arbiter_if.slave bus
);
    localparam int c_id_w  = $clog2(NUM_REQ);
    localparam int c_cnt_w = $clog2(MAX_OUT) + 1;

    logic [c_id_w-1:0]  r_ptr;
    logic               r_issue;
    logic [DATA_W-1:0]  r_mean_a;
    logic [DATA_W-1:0]  r_mean_b;
    logic               r_mean_sign;
    logic               r_rsp_valid;
    logic [c_id_w-1:0]  r_rsp_id;
    logic [DATA_W-1:0]  r_rsp_data;
    logic               r_spurious_err;

    logic [NUM_REQ-1:0] w_rot;
    logic               w_found;
    logic [c_id_w:0]    w_sum;
    logic [c_id_w-1:0]  w_gnt_idx;
    logic               w_grant;
    logic               w_push;
    logic               w_pop;
    logic               w_flush;
    logic [c_id_w-1:0]  w_head;
    logic               w_full;
    logic               w_empty;
    logic [c_cnt_w-1:0] w_count;

    // ------------------------------------------------------------------
    // Round-robin selection: rotate so the pointer channel sits at bit 0,
    // take the lowest set bit, then map back to an absolute channel.
    // ------------------------------------------------------------------
    assign w_rot = NUM_REQ'({bus.req_valid, bus.req_valid} >> r_ptr);

    always_comb begin
        w_found   = 1'b0;
        w_sum     = '0;
        w_gnt_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, r_ptr} + (c_id_w+1)'(k);
                if (w_sum >= (c_id_w+1)'(NUM_REQ)) begin
                    w_sum = w_sum - (c_id_w+1)'(NUM_REQ);
                end
                w_gnt_idx = w_sum[c_id_w-1:0];
            end
        end
    end

    // Occupancy check uses the registered count, so a same-cycle pop never
    // frees a slot early.
    assign w_grant = bus.enable & w_found & (w_count < c_cnt_w'(MAX_OUT)) & ~w_flush;
    assign w_push  = w_grant & ~w_full;
    assign w_pop   = bus.mean_output_strobe & ~w_empty;

    always_comb begin
        bus.req_ready = '0;
        if (w_grant) begin
            bus.req_ready[w_gnt_idx] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Issue stage: operands captured on grant, held until the next grant.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr       <= '0;
            r_issue     <= 1'b0;
            r_mean_a    <= '0;
            r_mean_b    <= '0;
            r_mean_sign <= 1'b0;
        end else begin
            r_issue <= w_grant;
            if (w_grant) begin
                r_mean_a    <= bus.req_a[w_gnt_idx*DATA_W +: DATA_W];
                r_mean_b    <= bus.req_b[w_gnt_idx*DATA_W +: DATA_W];
                r_mean_sign <= bus.req_sign[w_gnt_idx];
                r_ptr       <= c_id_w'(rr_next(int'(w_gnt_idx), NUM_REQ));
            end
        end
    end

    assign bus.mean_a            = r_mean_a;
    assign bus.mean_b            = r_mean_b;
    assign bus.mean_sign         = r_mean_sign;
    assign bus.mean_input_strobe = r_issue;

    // ------------------------------------------------------------------
    // Result stage: each datapath result is paired with the oldest tag.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rsp_valid    <= 1'b0;
            r_rsp_id       <= '0;
            r_rsp_data     <= '0;
            r_spurious_err <= 1'b0;
        end else begin
            r_rsp_valid <= w_pop;
            if (w_pop) begin
                r_rsp_id   <= w_head;
                r_rsp_data <= bus.mean_c;
            end
            if (bus.mean_output_strobe && w_empty) begin
                r_spurious_err <= 1'b1;
            end
        end
    end

    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_id       = r_rsp_id;
    assign bus.rsp_data     = r_rsp_data;
    assign bus.busy         = ~w_empty;
    assign bus.spurious_err = r_spurious_err;

`ifdef MEAN_ARBITER_TIMEOUT_EN
    // ------------------------------------------------------------------
    // Watchdog: counts busy cycles without a result; reloads on each pop.
    // ------------------------------------------------------------------
    localparam int c_to_w = $clog2(TIMEOUT + 1);

    logic [c_to_w-1:0] r_to_cnt;
    logic              r_timeout_err;

    assign w_flush = ~w_empty & ~w_pop & (r_to_cnt == c_to_w'(TIMEOUT - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_empty || w_pop || w_flush) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_flush) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign bus.timeout_err = r_timeout_err;
`else
    assign w_flush = 1'b0;
`endif

    mean_arbiter_tag_fifo #(
        .TAG_W     (c_id_w),
        .DEPTH     (MAX_OUT),
        .CNT_WIDTH (c_cnt_w)
    ) u_tag_fifo (
        .clk     (clock),
        .rst     (reset),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_tag   (w_gnt_idx),
        .i_pop   (w_pop),
        .o_tag   (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_mean_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mean_arbiter
// Purpose  : Self-checking bench for mean_arbiter: an in-order datapath
//            model with configurable latency/stall, a queue-based reference
//            model compared every cycle, directed literal checks and a
//            randomized phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mean_arbiter;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int MO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mean_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus();

    mean_arbiter #(.NUM_REQ(N), .DATA_W(W), .MAX_OUT(MO)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- datapath model (in-order, shares reset) ------------
    typedef struct {
        logic [W-1:0] c;
        int           due;
    } dp_t;

    dp_t dp_q[$];
    int  dp_lat     = 3;
    int  dp_credit  = 1000000;
    bit  force_spur = 1'b0;

    function automatic logic [W-1:0] dp_mean(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
        logic [W:0] sum;
        if (s) sum = {a[W-1], a} + {b[W-1], b};
        else   sum = {1'b0, a} + {1'b0, b};
        return sum[W:1];
    endfunction

    always @(posedge clk) begin
        cyc++;
        #1;
        if (force_spur) begin
            bus.mean_output_strobe = 1'b1;
            bus.mean_c             = 16'h1234;
            force_spur             = 1'b0;
        end else if (dp_q.size() > 0 && dp_q[0].due <= cyc && dp_credit > 0) begin
            bus.mean_output_strobe = 1'b1;
            bus.mean_c             = dp_q[0].c;
            void'(dp_q.pop_front());
            dp_credit--;
        end else begin
            bus.mean_output_strobe = 1'b0;
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    int           m_ptr;
    int           m_q[$];
    bit           m_strobe;
    logic [W-1:0] m_a, m_b;
    bit           m_s;
    bit           m_rv;
    int           m_rid;
    logic [W-1:0] m_rd;
    bit           m_spur;

    int           gnt_log[$];
    int           rsp_id_log[$];
    int           rsp_dat_log[$];

    always @(negedge clk) begin
        int g;
        logic [N-1:0] exp_rdy;
        if (rst) begin
            m_ptr = 0; m_q.delete(); m_strobe = 0; m_a = '0; m_b = '0; m_s = 0;
            m_rv = 0; m_rid = 0; m_rd = '0; m_spur = 0;
            dp_q.delete();
        end else begin
            g = -1;
            if (bus.enable && m_q.size() < MO) begin
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && bus.req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
                end
            end
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;

            chk("req_ready", bus.req_ready, exp_rdy);
            chk("in_strobe", bus.mean_input_strobe, m_strobe);
            chk("mean_a", bus.mean_a, m_a);
            chk("mean_b", bus.mean_b, m_b);
            chk("mean_sign", bus.mean_sign, m_s);
            chk("rsp_valid", bus.rsp_valid, m_rv);
            if (m_rv) begin
                chk("rsp_id", bus.rsp_id, m_rid);
                chk("rsp_data", bus.rsp_data, m_rd);
            end
            chk("busy", bus.busy, m_q.size() != 0);
            chk("spurious_err", bus.spurious_err, m_spur);

            for (int k = 0; k < N; k++) if (bus.req_ready[k]) gnt_log.push_back(k);
            if (bus.rsp_valid) begin
                rsp_id_log.push_back(int'(bus.rsp_id));
                rsp_dat_log.push_back(int'(bus.rsp_data));
            end
            if (bus.mean_input_strobe)
                dp_q.push_back('{c: dp_mean(bus.mean_a, bus.mean_b, bus.mean_sign),
                                 due: cyc + dp_lat});

            // state advance: pop decision before push, both on pre-edge occupancy
            m_rv = 0;
            if (bus.mean_output_strobe) begin
                if (m_q.size() > 0) begin
                    m_rv  = 1;
                    m_rid = m_q.pop_front();
                    m_rd  = bus.mean_c;
                end else begin
                    m_spur = 1;
                end
            end
            m_strobe = 0;
            if (g >= 0) begin
                m_q.push_back(g);
                m_strobe = 1;
                m_a   = bus.req_a[g*W +: W];
                m_b   = bus.req_b[g*W +: W];
                m_s   = bus.req_sign[g];
                m_ptr = (g + 1) % N;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.req_valid = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic clear_logs();
        gnt_log.delete();
        rsp_id_log.delete();
        rsp_dat_log.delete();
    endtask

    initial begin
        int exp6[6];
        exp6 = '{0, 1, 2, 3, 0, 1};
        bus.enable    = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_sign  = '0;
        do_reset();

        // reset state
        @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_in_strobe", bus.mean_input_strobe, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_spurious", bus.spurious_err, 0);

        // A: ch0 signed -31, 11
        step();
        clear_logs();
        bus.enable          = 1'b1;
        bus.req_a[0 +: W]   = 16'hFFE1;
        bus.req_b[0 +: W]   = 16'd11;
        bus.req_sign        = 4'b0001;
        bus.req_valid       = 4'b0001;
        @(negedge clk);
        chk("A_ready", bus.req_ready, 4'b0001);
        step();
        bus.req_valid = '0;
        @(negedge clk);
        chk("A_strobe", bus.mean_input_strobe, 1);
        chk("A_mean_a", bus.mean_a, 16'hFFE1);
        chk("A_mean_b", bus.mean_b, 16'h000B);
        chk("A_sign", bus.mean_sign, 1);
        repeat (8) step();
        chk("A_rsp_count", rsp_id_log.size(), 1);
        if (rsp_id_log.size() >= 1) begin
            chk("A_rsp_id", rsp_id_log[0], 0);
            chk("A_rsp_data", rsp_dat_log[0], 16'hFFF6);
        end

        // B: ch1 unsigned 11, 21
        clear_logs();
        bus.req_a[W +: W] = 16'd11;
        bus.req_b[W +: W] = 16'd21;
        bus.req_sign      = 4'b0000;
        bus.req_valid     = 4'b0010;
        step();
        bus.req_valid = '0;
        repeat (8) step();
        chk("B_gnt_count", gnt_log.size(), 1);
        chk("B_rsp_count", rsp_id_log.size(), 1);
        if (rsp_id_log.size() >= 1) begin
            chk("B_rsp_id", rsp_id_log[0], 1);
            chk("B_rsp_data", rsp_dat_log[0], 16);
        end

        // C: all channels valid, latency 3
        do_reset();
        clear_logs();
        bus.req_a     = {$urandom, $urandom};
        bus.req_b     = {$urandom, $urandom};
        bus.req_sign  = 4'($urandom);
        bus.req_valid = 4'hF;
        repeat (8) step();
        bus.req_valid = '0;
        repeat (12) step();
        chk("C_gnt_enough", gnt_log.size() >= 6, 1);
        chk("C_rsp_enough", rsp_id_log.size() >= 6, 1);
        for (int i = 0; i < 6; i++) begin
            if (i < gnt_log.size())    chk("C_gnt_order", gnt_log[i], exp6[i]);
            if (i < rsp_id_log.size()) chk("C_rsp_order", rsp_id_log[i], exp6[i]);
        end

        // D: datapath stalled -> exactly MAX_OUT grants, then one per result
        do_reset();
        clear_logs();
        dp_credit     = 0;
        bus.req_valid = 4'hF;
        repeat (10) step();
        chk("D_gnt_full", gnt_log.size(), 4);
        chk("D_busy", bus.busy, 1);
        chk("D_ready_blocked", bus.req_ready, 0);
        dp_credit = 1;
        repeat (6) step();
        chk("D_gnt_after_pop", gnt_log.size(), 5);
        chk("D_rsp_count", rsp_id_log.size(), 1);
        dp_credit     = 1000000;
        bus.req_valid = '0;
        repeat (15) step();
        chk("D_drained", bus.busy, 0);

        // E: result strobe with nothing outstanding
        do_reset();
        clear_logs();
        force_spur = 1'b1;
        repeat (4) step();
        chk("E_spurious", bus.spurious_err, 1);
        chk("E_no_rsp", rsp_id_log.size(), 0);
        do_reset();
        chk("E_spurious_cleared", bus.spurious_err, 0);

        // Randomized traffic with one mid-run reset
        for (int i = 0; i < 400; i++) begin
            step();
            rst           = (i == 200);
            bus.req_valid = 4'($urandom);
            bus.req_a     = {$urandom, $urandom};
            bus.req_b     = {$urandom, $urandom};
            bus.req_sign  = 4'($urandom);
            bus.enable    = ($urandom_range(0, 9) != 0);
            dp_credit     = ($urandom_range(0, 3) != 0) ? 1000000 : 0;
            dp_lat        = $urandom_range(1, 4);
        end
        step();
        rst           = 1'b0;
        bus.req_valid = '0;
        dp_credit     = 1000000;
        repeat (20) step();
        chk("R_drained", bus.busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
`default_nettype wire
